// File: rtl/color_detect_pkg.sv
// Shared types for the ROI colour detector: overlay colour code, per-frame
// class, committed-state encoding and the pixel counter width.
package color_detect_pkg;

   localparam int CNT_W = 17;

   typedef logic [CNT_W-1:0] cnt_t;

   // Encoding is fixed by the overlay consumer.
   typedef enum logic [1:0] {
      C_NONE  = 2'b00,
      C_RED   = 2'b01,
      C_GREEN = 2'b10,
      C_BLUE  = 2'b11
   } color_t;

   // Low two bits of the colour classes line up with color_t.
   typedef enum logic [2:0] {
      FC_NONE  = 3'd0,
      FC_RED   = 3'd1,
      FC_GREEN = 3'd2,
      FC_BLUE  = 3'd3,
      FC_WHITE = 3'd4
   } frame_class_t;

   typedef enum logic [1:0] {
      S_WHITE  = 2'd0,
      S_SEARCH = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   function automatic cnt_t sat_inc(input cnt_t c, input logic en);
      return (en && (c != '1)) ? c + cnt_t'(1) : c;
   endfunction

endpackage

// File: rtl/pixel_color_classifier.sv
// Combinational per-pixel classifier producing a one-hot {white, red, green, blue}.
// White takes priority; a colour needs its channel above both others by more than the margin.
module pixel_color_classifier
   import color_detect_pkg::*;
(
   input  logic [3:0] pixel_r,
   input  logic [3:0] pixel_g,
   input  logic [3:0] pixel_b,
   input  logic [3:0] color_margin,
   input  logic [3:0] white_min,
   output logic [3:0] pixel_hot
);

   logic [4:0] r5, g5, b5, m5;
   logic       is_white, is_red, is_green, is_blue;

   assign r5 = {1'b0, pixel_r};
   assign g5 = {1'b0, pixel_g};
   assign b5 = {1'b0, pixel_b};
   assign m5 = {1'b0, color_margin};

   assign is_white = (pixel_r >= white_min) && (pixel_g >= white_min) && (pixel_b >= white_min);
   assign is_red   = (r5 > g5 + m5) && (r5 > b5 + m5);
   assign is_green = (g5 > r5 + m5) && (g5 > b5 + m5);
   assign is_blue  = (b5 > r5 + m5) && (b5 > g5 + m5);

   // At most one colour can win the strict margin test, so masking by white keeps one-hot.
   assign pixel_hot = {is_white,
                       is_red   && !is_white,
                       is_green && !is_white,
                       is_blue  && !is_white};

endmodule

// File: rtl/roi_color_classifier.sv
// Counts classified ROI pixels per frame, picks a frame class at each frame_start,
// debounces it across frames and drives the committed colour/white outputs.
module roi_color_classifier
   import color_detect_pkg::*;
#(
   parameter logic [9:0]       ROI_X_START   = 10'd100,
   parameter logic [9:0]       ROI_X_END     = 10'd220,
   parameter logic [9:0]       ROI_Y_START   = 10'd60,
   parameter logic [9:0]       ROI_Y_END     = 10'd180,
   parameter logic [3:0]       COLOR_MARGIN  = 4'd3,
   parameter logic [3:0]       WHITE_MIN     = 4'd12,
   parameter logic [CNT_W-1:0] MIN_PIXELS    = 17'd2000,
   parameter logic [CNT_W-1:0] WHITE_PIXELS  = 17'd10000,
   parameter logic [3:0]       STABLE_FRAMES = 4'd3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_start,
   input  logic       pixel_valid,
   input  logic [9:0] x_coord,
   input  logic [9:0] y_coord,
   input  logic [3:0] pixel_r,
   input  logic [3:0] pixel_g,
   input  logic [3:0] pixel_b,
   output logic [1:0] dominant_color,
   output logic       white_detected,
   output logic       color_changed,
   output logic       turn_end
);

   // Counter index: 3 white, 2 red, 1 green, 0 blue (matches pixel_hot bit order).
   logic [3:0]   pixel_hot;
   logic         in_roi;
   logic [3:0]   inc;
   cnt_t         cnt [4];

   frame_class_t frame_class;
   frame_class_t class_q;
   logic         class_v;
   logic         primed;

   frame_class_t cand, cand_nxt;
   logic [3:0]   run, run_nxt;
   logic         commit;

   state_t       state, state_nxt;
   color_t       dom_q, dom_nxt;
   logic         white_q, white_nxt;
   logic         changed_q, changed_nxt;
   logic         turn_q, turn_nxt;

   pixel_color_classifier u_classify (
      .pixel_r      (pixel_r),
      .pixel_g      (pixel_g),
      .pixel_b      (pixel_b),
      .color_margin (COLOR_MARGIN),
      .white_min    (WHITE_MIN),
      .pixel_hot    (pixel_hot)
   );

   assign in_roi = (x_coord >= ROI_X_START) && (x_coord < ROI_X_END) &&
                   (y_coord >= ROI_Y_START) && (y_coord < ROI_Y_END);
   assign inc    = (pixel_valid && in_roi) ? pixel_hot : 4'b0000;

   // A pixel arriving with frame_start belongs to the new frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 4; k++) cnt[k] <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (frame_start) cnt[k] <= cnt_t'(inc[k]);
            else             cnt[k] <= sat_inc(cnt[k], inc[k]);
         end
      end
   end

   // Frame class from the closing counts; ties resolve red > green > blue.
   always_comb begin
      frame_class = FC_NONE;
      if (cnt[3] >= WHITE_PIXELS) begin
         frame_class = FC_WHITE;
      end else if ((cnt[2] >= cnt[1]) && (cnt[2] >= cnt[0])) begin
         if (cnt[2] >= MIN_PIXELS) frame_class = FC_RED;
      end else if (cnt[1] >= cnt[0]) begin
         if (cnt[1] >= MIN_PIXELS) frame_class = FC_GREEN;
      end else begin
         if (cnt[0] >= MIN_PIXELS) frame_class = FC_BLUE;
      end
   end

   // The frame closed by the first frame_start after reset is partial and never evaluated.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         primed  <= 1'b0;
         class_v <= 1'b0;
         class_q <= FC_NONE;
      end else begin
         class_v <= frame_start && primed;
         if (frame_start) begin
            primed  <= 1'b1;
            class_q <= frame_class;
         end
      end
   end

   always_comb begin
      cand_nxt = cand;
      run_nxt  = run;
      commit   = 1'b0;
      if (class_v) begin
         if (class_q == cand) begin
            if (run != 4'hF) begin
               run_nxt = run + 4'd1;
               commit  = ((run + 4'd1) == STABLE_FRAMES);
            end
         end else begin
            cand_nxt = class_q;
            run_nxt  = 4'd1;
            commit   = (STABLE_FRAMES == 4'd1);
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      dom_nxt     = dom_q;
      changed_nxt = 1'b0;
      turn_nxt    = 1'b0;
      if (commit) begin
         case (cand_nxt)
            FC_WHITE: begin state_nxt = S_WHITE;  dom_nxt = C_NONE; end
            FC_NONE:  begin state_nxt = S_SEARCH; dom_nxt = C_NONE; end
            default:  begin state_nxt = S_LOCKED; dom_nxt = color_t'(cand_nxt[1:0]); end
         endcase
         changed_nxt = (state_nxt != state) || (dom_nxt != dom_q);
         turn_nxt    = (state == S_LOCKED) && (state_nxt == S_WHITE);
      end
      white_nxt = (state_nxt == S_WHITE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cand      <= FC_WHITE;
         run       <= 4'd0;
         state     <= S_WHITE;
         dom_q     <= C_NONE;
         white_q   <= 1'b1;
         changed_q <= 1'b0;
         turn_q    <= 1'b0;
      end else begin
         cand      <= cand_nxt;
         run       <= run_nxt;
         state     <= state_nxt;
         dom_q     <= dom_nxt;
         white_q   <= white_nxt;
         changed_q <= changed_nxt;
         turn_q    <= turn_nxt;
      end
   end

   assign dominant_color = dom_q;
   assign white_detected = white_q;
   assign color_changed  = changed_q;
   assign turn_end       = turn_q;

endmodule

// File: tb/tb_roi_color_classifier.sv
// Directed bench for roi_color_classifier with reduced pixel thresholds so each frame stays short.
module tb_roi_color_classifier;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_start = 1'b0;
   logic       pixel_valid = 1'b0;
   logic [9:0] x_coord = '0;
   logic [9:0] y_coord = '0;
   logic [3:0] pixel_r = '0;
   logic [3:0] pixel_g = '0;
   logic [3:0] pixel_b = '0;
   logic [1:0] dominant_color;
   logic       white_detected;
   logic       color_changed;
   logic       turn_end;

   int n_checks = 0;
   int n_fail   = 0;
   int cc_cnt   = 0;
   int te_cnt   = 0;
   int both_cnt = 0;
   int pix_idx  = 0;
   int c0, t0, b0;

   roi_color_classifier #(
      .MIN_PIXELS    (17'd50),
      .WHITE_PIXELS  (17'd200),
      .STABLE_FRAMES (4'd3)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .frame_start    (frame_start),
      .pixel_valid    (pixel_valid),
      .x_coord        (x_coord),
      .y_coord        (y_coord),
      .pixel_r        (pixel_r),
      .pixel_g        (pixel_g),
      .pixel_b        (pixel_b),
      .dominant_color (dominant_color),
      .white_detected (white_detected),
      .color_changed  (color_changed),
      .turn_end       (turn_end)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (color_changed) cc_cnt++;
      if (turn_end) te_cnt++;
      if (color_changed && turn_end) both_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic drive_pixels(input int n, input logic [11:0] c, input bit outside);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         pixel_valid = 1'b1;
         {pixel_r, pixel_g, pixel_b} = c;
         if (!outside) begin
            x_coord = 10'(100 + pix_idx % 120);
            y_coord = 10'(60 + pix_idx / 120);
            pix_idx = (pix_idx + 1) % 14400;
         end else begin
            case (i % 4)
               0: begin x_coord = 10'd99;  y_coord = 10'd100; end
               1: begin x_coord = 10'd220; y_coord = 10'd100; end
               2: begin x_coord = 10'd150; y_coord = 10'd59;  end
               default: begin x_coord = 10'd150; y_coord = 10'd180; end
            endcase
         end
      end
      @(negedge clk);
      pixel_valid = 1'b0;
   endtask

   task automatic fill(input int n1, input logic [11:0] k1, input int n2, input logic [11:0] k2,
                       input int n3, input logic [11:0] k3, input int n_out, input logic [11:0] k_out);
      drive_pixels(n1, k1, 1'b0);
      drive_pixels(n2, k2, 1'b0);
      drive_pixels(n3, k3, 1'b0);
      drive_pixels(n_out, k_out, 1'b1);
   endtask

   // Returns one cycle after frame_start was sampled.
   task automatic pulse_frame_start();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic close_frame();
      pulse_frame_start();
      repeat (3) @(negedge clk);
   endtask

   task automatic snap();
      c0 = cc_cnt; t0 = te_cnt; b0 = both_cnt;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++; if (white_detected !== 1'b1) begin n_fail++; $display("FAIL reset_white: got %b expected 1", white_detected); end
      n_checks++; if (dominant_color !== 2'b00) begin n_fail++; $display("FAIL reset_dom: got %b expected 00", dominant_color); end
      n_checks++; if (color_changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed: got %b expected 0", color_changed); end
      n_checks++; if (turn_end !== 1'b0) begin n_fail++; $display("FAIL reset_turn_end: got %b expected 0", turn_end); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_white_hold();
      close_frame();
      snap();
      for (int f = 0; f < 4; f++) begin
         fill(200, 12'hFFF, 0, 12'h000, 0, 12'h000, 0, 12'h000);
         close_frame();
      end
      n_checks++; if (white_detected !== 1'b1) begin n_fail++; $display("FAIL white_hold_white: got %b expected 1", white_detected); end
      n_checks++; if (dominant_color !== 2'b00) begin n_fail++; $display("FAIL white_hold_dom: got %b expected 00", dominant_color); end
      n_checks++; if (cc_cnt - c0 !== 0) begin n_fail++; $display("FAIL white_hold_changed: got %0d pulses expected 0", cc_cnt - c0); end
      n_checks++; if (te_cnt - t0 !== 0) begin n_fail++; $display("FAIL white_hold_turn_end: got %0d pulses expected 0", te_cnt - t0); end
   endtask

   task automatic test_red_lock();
      snap();
      for (int f = 0; f < 2; f++) begin
         fill(50, 12'h844, 100, 12'h744, 0, 12'h000, 20, 12'hF00);
         close_frame();
      end
      n_checks++; if (dominant_color !== 2'b00) begin n_fail++; $display("FAIL red_early_dom: got %b expected 00", dominant_color); end
      fill(50, 12'h844, 100, 12'h744, 0, 12'h000, 20, 12'hF00);
      pulse_frame_start();
      n_checks++; if (dominant_color !== 2'b00 || white_detected !== 1'b1) begin n_fail++; $display("FAIL red_lat_n1: got dom %b white %b expected 00 1", dominant_color, white_detected); end
      @(negedge clk);
      n_checks++; if (dominant_color !== 2'b01) begin n_fail++; $display("FAIL red_lat_dom: got %b expected 01", dominant_color); end
      n_checks++; if (white_detected !== 1'b0) begin n_fail++; $display("FAIL red_lat_white: got %b expected 0", white_detected); end
      n_checks++; if (color_changed !== 1'b1 || turn_end !== 1'b0) begin n_fail++; $display("FAIL red_lat_pulse: got changed %b turn_end %b expected 1 0", color_changed, turn_end); end
      @(negedge clk);
      n_checks++; if (color_changed !== 1'b0) begin n_fail++; $display("FAIL red_pulse_width: got %b expected 0", color_changed); end
      repeat (2) @(negedge clk);
      n_checks++; if (cc_cnt - c0 !== 1 || te_cnt - t0 !== 0) begin n_fail++; $display("FAIL red_pulse_count: got changed %0d turn_end %0d expected 1 0", cc_cnt - c0, te_cnt - t0); end
   endtask

   task automatic test_turn_end();
      snap();
      for (int f = 0; f < 2; f++) begin
         fill(200, 12'hCCC, 0, 12'h000, 0, 12'h000, 0, 12'h000);
         close_frame();
      end
      n_checks++; if (dominant_color !== 2'b01) begin n_fail++; $display("FAIL turn_early_dom: got %b expected 01", dominant_color); end
      fill(200, 12'hCCC, 0, 12'h000, 0, 12'h000, 0, 12'h000);
      pulse_frame_start();
      @(negedge clk);
      n_checks++; if (turn_end !== 1'b1 || color_changed !== 1'b1) begin n_fail++; $display("FAIL turn_pulse: got turn_end %b changed %b expected 1 1", turn_end, color_changed); end
      n_checks++; if (white_detected !== 1'b1 || dominant_color !== 2'b00) begin n_fail++; $display("FAIL turn_outputs: got white %b dom %b expected 1 00", white_detected, dominant_color); end
      repeat (3) @(negedge clk);
      n_checks++; if (cc_cnt - c0 !== 1 || te_cnt - t0 !== 1 || both_cnt - b0 !== 1) begin n_fail++; $display("FAIL turn_counts: got changed %0d turn_end %0d same_cycle %0d expected 1 1 1", cc_cnt - c0, te_cnt - t0, both_cnt - b0); end
   endtask

   task automatic test_alternate();
      snap();
      for (int f = 0; f < 5; f++) begin
         if (f % 2 == 0) fill(60, 12'h844, 0, 12'h000, 0, 12'h000, 0, 12'h000);
         else            fill(60, 12'h484, 0, 12'h000, 0, 12'h000, 0, 12'h000);
         close_frame();
      end
      n_checks++; if (white_detected !== 1'b1 || dominant_color !== 2'b00) begin n_fail++; $display("FAIL alt_outputs: got white %b dom %b expected 1 00", white_detected, dominant_color); end
      n_checks++; if (cc_cnt - c0 !== 0 || te_cnt - t0 !== 0) begin n_fail++; $display("FAIL alt_pulses: got changed %0d turn_end %0d expected 0 0", cc_cnt - c0, te_cnt - t0); end
   endtask

   task automatic test_ties();
      snap();
      for (int f = 0; f < 3; f++) begin
         fill(60, 12'h484, 60, 12'h448, 0, 12'h000, 0, 12'h000);
         close_frame();
      end
      n_checks++; if (dominant_color !== 2'b10 || white_detected !== 1'b0) begin n_fail++; $display("FAIL tie_green: got dom %b white %b expected 10 0", dominant_color, white_detected); end
      for (int f = 0; f < 3; f++) begin
         fill(70, 12'h844, 70, 12'h484, 70, 12'h448, 0, 12'h000);
         close_frame();
      end
      n_checks++; if (dominant_color !== 2'b01) begin n_fail++; $display("FAIL tie_red: got dom %b expected 01", dominant_color); end
      n_checks++; if (cc_cnt - c0 !== 2 || te_cnt - t0 !== 0) begin n_fail++; $display("FAIL tie_pulses: got changed %0d turn_end %0d expected 2 0", cc_cnt - c0, te_cnt - t0); end
   endtask

   task automatic test_none();
      snap();
      for (int f = 0; f < 3; f++) begin
         fill(49, 12'h448, 100, 12'h888, 100, 12'h744, 20, 12'h44F);
         drive_pixels(60, 12'hBFF, 1'b0);
         close_frame();
      end
      n_checks++; if (dominant_color !== 2'b00 || white_detected !== 1'b0) begin n_fail++; $display("FAIL none_outputs: got dom %b white %b expected 00 0", dominant_color, white_detected); end
      n_checks++; if (cc_cnt - c0 !== 1 || te_cnt - t0 !== 0) begin n_fail++; $display("FAIL none_pulses: got changed %0d turn_end %0d expected 1 0", cc_cnt - c0, te_cnt - t0); end
      snap();
      for (int f = 0; f < 3; f++) begin
         fill(60, 12'h448, 59, 12'h844, 0, 12'h000, 0, 12'h000);
         close_frame();
      end
      n_checks++; if (dominant_color !== 2'b11 || white_detected !== 1'b0) begin n_fail++; $display("FAIL blue_outputs: got dom %b white %b expected 11 0", dominant_color, white_detected); end
      n_checks++; if (cc_cnt - c0 !== 1 || te_cnt - t0 !== 0) begin n_fail++; $display("FAIL blue_pulses: got changed %0d turn_end %0d expected 1 0", cc_cnt - c0, te_cnt - t0); end
   endtask

   task automatic test_reset_mid();
      drive_pixels(40, 12'h448, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++; if (white_detected !== 1'b1 || dominant_color !== 2'b00) begin n_fail++; $display("FAIL mid_reset_async: got white %b dom %b expected 1 00", white_detected, dominant_color); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      snap();
      for (int f = 0; f < 3; f++) begin
         fill(60, 12'h448, 0, 12'h000, 0, 12'h000, 0, 12'h000);
         close_frame();
      end
      n_checks++; if (white_detected !== 1'b1 || dominant_color !== 2'b00) begin n_fail++; $display("FAIL mid_reset_primed: got white %b dom %b expected 1 00", white_detected, dominant_color); end
      n_checks++; if (cc_cnt - c0 !== 0) begin n_fail++; $display("FAIL mid_reset_pulses: got changed %0d expected 0", cc_cnt - c0); end
      fill(60, 12'h448, 0, 12'h000, 0, 12'h000, 0, 12'h000);
      close_frame();
      n_checks++; if (dominant_color !== 2'b11 || cc_cnt - c0 !== 1 || te_cnt - t0 !== 0) begin n_fail++; $display("FAIL mid_reset_relock: got dom %b changed %0d turn_end %0d expected 11 1 0", dominant_color, cc_cnt - c0, te_cnt - t0); end
   endtask

   task automatic test_back_to_back();
      snap();
      fill(200, 12'hFFF, 0, 12'h000, 0, 12'h000, 0, 12'h000);
      @(negedge clk);
      frame_start = 1'b1;
      repeat (4) @(negedge clk);
      frame_start = 1'b0;
      n_checks++; if (dominant_color !== 2'b11) begin n_fail++; $display("FAIL b2b_hold: got dom %b expected 11", dominant_color); end
      @(negedge clk);
      n_checks++; if (dominant_color !== 2'b00 || white_detected !== 1'b0 || color_changed !== 1'b1) begin n_fail++; $display("FAIL b2b_commit: got dom %b white %b changed %b expected 00 0 1", dominant_color, white_detected, color_changed); end
      repeat (3) @(negedge clk);
      n_checks++; if (cc_cnt - c0 !== 1 || te_cnt - t0 !== 0) begin n_fail++; $display("FAIL b2b_pulses: got changed %0d turn_end %0d expected 1 0", cc_cnt - c0, te_cnt - t0); end
   endtask

   initial begin
      test_reset();
      test_white_hold();
      test_red_lock();
      test_turn_end();
      test_alternate();
      test_ties();
      test_none();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
